key_valid_ctrl: RTL and testbench
=================================

# key_valid_ctrl

Input-side controller for the LED chaser: debounces one raw push-button and produces the `valid` level that enables the running-light block. A short press toggles `valid`; a long press forces `valid` low. One-cycle event pulses are also provided. The block sits between the board key pin and the chaser's `valid` input, in the 50 MHz `sys_clk` domain.

## Interface
- `DEBOUNCE_CNT`, default 999_999: a level change must be stable for DEBOUNCE_CNT+1 cycles (20 ms at 50 MHz).
- `LONG_CNT`, default 49_999_999: hold cycles in PRESSED before a long press is declared (1 s).
- `KEY_ACTIVE`, default 1'b0: raw `key_in` level that means "pressed".

- `sys_clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `key_in` in 1: raw button pin, asynchronous and bouncing.
- `valid` out 1: run enable level for the chaser.
- `key_state` out 1: debounced key, 1 = pressed.
- `press_pulse` out 1: one-cycle strobe for a completed short press.
- `long_pulse` out 1: one-cycle strobe when a long press is detected.

## Operation
- **Reset:** `valid`, `key_state`, `press_pulse` and `long_pulse` are all 0. FSM is IDLE and all counters are 0. Both synchronizer flops reset to the released level (`~KEY_ACTIVE`).
- **Synchronizer:** two flops on `key_in`, then normalized so that `key_sync` = 1 means pressed.
- **Debounce:**
  - If `key_sync != key_state`, `db_cnt` increments.
  - When `db_cnt == DEBOUNCE_CNT` and the mismatch persists, `key_state <= key_sync` and `db_cnt <= 0`.
  - If `key_sync == key_state`, `db_cnt <= 0`. Any glitch shorter than DEBOUNCE_CNT+1 cycles is discarded.
- **FSM states:** IDLE, PRESSED, LONG.
  - IDLE: on `key_state` 0→1, go to PRESSED with `hold_cnt <= 0`.
  - PRESSED, `key_state == 0` (release): pulse `press_pulse` for 1 cycle, `valid <= ~valid`, go to IDLE.
  - PRESSED, else if `hold_cnt == LONG_CNT`: pulse `long_pulse` for 1 cycle, `valid <= 0`, go to LONG.
  - PRESSED, otherwise: `hold_cnt <= hold_cnt + 1`.
  - LONG: stay until `key_state == 0`, then go to IDLE. No `press_pulse` is generated.
- **Widths:**
  - `db_cnt` is `$clog2(DEBOUNCE_CNT+1)` bits.
  - `hold_cnt` is `$clog2(LONG_CNT+1)` bits.
  - Counters saturate by construction and never wrap.
- **Simultaneous release and `hold_cnt == LONG_CNT`:** release has priority, so the event is a short press (toggle).
- **Long press with `valid` already 0:** `long_pulse` still fires and `valid` stays 0.
- **Reset mid-operation:** all state clears immediately. A key still held after reset is seen as a fresh press once debounced; the toggle fires on its release.
- All outputs are registered with no combinational paths from input to output.

## Timing
- Take edge 0 as the first `sys_clk` edge after a clean `key_in` transition. The synchronizer output is valid after edge 2.
- `key_state` changes after edge DEBOUNCE_CNT+3.
- **Press:** with `key_state` rising after edge P, the FSM enters PRESSED after edge P+1.
- **Long press:** `long_pulse` is high for exactly the cycle after edge P+LONG_CNT+2. `valid` goes low on the same edge.
- **Release:** with `key_state` falling after edge R while in PRESSED, `press_pulse` is high for the cycle after edge R+1. `valid` toggles on that same edge.
- Minimum key-to-`valid` latency is DEBOUNCE_CNT+4 cycles, measured from the release transition.
- `press_pulse` and `long_pulse` are never high in the same cycle, and neither is high for more than one cycle.

## Test plan
All scenarios use DEBOUNCE_CNT=3, LONG_CNT=20, KEY_ACTIVE=0.

1. **Reset:** assert `rst` for 3 cycles with `key_in` held at 1 → all outputs 0; no pulses for 50 cycles after release of `rst`.
2. **Bounce rejection:** `key_in` low for 3 cycles, then high, repeated 5 times → `key_state` stays 0 and no pulses occur.
3. **Short press:** `key_in` low for 10 cycles, then high.
   - `key_state` rises 6 cycles after the fall.
   - `press_pulse` fires 1 cycle after `key_state` falls.
   - `valid` goes 0→1. A second identical press returns `valid` to 0.
4. **Long press:**
   - With `valid` = 1, hold `key_in` low for 40 cycles → `long_pulse` fires once, 22 cycles after `key_state` rises.
   - `valid` becomes 0.
   - On release: no `press_pulse`, and the FSM returns to IDLE.
5. **Boundary:** release timed so that `key_state` falls in the cycle where `hold_cnt == 20` → `press_pulse` fires, `valid` toggles, and no `long_pulse` occurs.
6. **Reset mid-press:** assert `rst` while in PRESSED with `valid` = 1, keeping the key held.
   - `valid` is 0 immediately.
   - After `rst` deasserts, `key_state` rises 6 cycles later.
   - On release, `valid` becomes 1.

Source files
------------

// File: rtl/key_valid_ctrl.sv
// Push-button front end for the LED chaser: synchronize, debounce and classify presses.
// A short press toggles valid, a long press forces it low; every output is a flop.
module key_valid_ctrl #(
    parameter int unsigned DEBOUNCE_CNT = 999_999,
    parameter int unsigned LONG_CNT     = 49_999_999,
    parameter logic        KEY_ACTIVE   = 1'b0
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic key_in,
    output logic valid,
    output logic key_state,
    output logic press_pulse,
    output logic long_pulse
);

    localparam int DB_W   = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam int HOLD_W = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CNT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] cnt);
        db_inc = (cnt == DB_MAX) ? cnt : cnt + 1'b1;
    endfunction

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt);
        hold_inc = (cnt == HOLD_MAX) ? cnt : cnt + 1'b1;
    endfunction

    logic key_meta_p0;
    logic key_raw_p1;
    logic key_sync_p2;

    logic [DB_W-1:0] db_cnt;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              valid_nxt;
    logic              press_nxt;
    logic              long_nxt;

    // Stage p0/p1: two-flop synchronizer, idle at the released pin level.
    // Stage p2: polarity-normalized copy, 1 = pressed.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            key_meta_p0 <= ~KEY_ACTIVE;
            key_raw_p1  <= ~KEY_ACTIVE;
            key_sync_p2 <= 1'b0;
        end else begin
            key_meta_p0 <= key_in;
            key_raw_p1  <= key_meta_p0;
            key_sync_p2 <= (key_raw_p1 == KEY_ACTIVE);
        end
    end

    // Debounce: a mismatch must survive DEBOUNCE_CNT+1 consecutive samples.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            db_cnt    <= '0;
            key_state <= 1'b0;
        end else if (key_sync_p2 == key_state) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            db_cnt    <= '0;
            key_state <= key_sync_p2;
        end else begin
            db_cnt <= db_inc(db_cnt);
        end
    end

    // Press classifier: release is checked before the long-press threshold.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        valid_nxt = valid;
        press_nxt = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_state) begin
                    state_nxt = ST_PRESSED;
                    hold_nxt  = '0;
                end
            end
            ST_PRESSED: begin
                if (!key_state) begin
                    press_nxt = 1'b1;
                    valid_nxt = ~valid;
                    state_nxt = ST_IDLE;
                end else if (hold_cnt == HOLD_MAX) begin
                    long_nxt  = 1'b1;
                    valid_nxt = 1'b0;
                    state_nxt = ST_LONG;
                end else begin
                    hold_nxt = hold_inc(hold_cnt);
                end
            end
            ST_LONG: begin
                if (!key_state) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            valid       <= 1'b0;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            valid       <= valid_nxt;
            press_pulse <= press_nxt;
            long_pulse  <= long_nxt;
        end
    end

endmodule

// File: tb/tb_key_valid_ctrl.sv
// Bench for key_valid_ctrl: directed press scenarios plus random key activity,
// compared every cycle against a window/timestamp reference model.
`timescale 1ns/1ps
module tb_key_valid_ctrl;

    localparam int D = 3;
    localparam int L = 20;

    logic sys_clk = 1'b0;
    logic rst;
    logic key_in;
    logic valid, key_state, press_pulse, long_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    key_valid_ctrl #(
        .DEBOUNCE_CNT(D),
        .LONG_CNT    (L),
        .KEY_ACTIVE  (1'b0)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .key_in     (key_in),
        .valid      (valid),
        .key_state  (key_state),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: pin history, debounce window, press timestamps.
    bit kq[$];
    bit sq[$];
    bit m_ks, m_valid, m_press, m_long, m_active, m_long_done;
    int m_enter;

    // Observed event bookkeeping.
    logic prev_ks = 1'b0;
    int fall_cyc = 0, rel_cyc = 0, rst_cyc = 0;
    int ks_rise_cyc = 0, ks_fall_cyc = 0, press_cyc = 0, long_cyc = 0;
    int n_ks_rise = 0, n_press = 0, n_long = 0;

    function automatic void model_reset();
        kq.delete();
        kq.push_back(1'b1);
        kq.push_back(1'b1);
        sq.delete();
        for (int i = 0; i <= D; i++) sq.push_back(1'b0);
        m_ks = 0; m_valid = 0; m_press = 0; m_long = 0;
        m_active = 0; m_long_done = 0; m_enter = 0;
    endfunction

    function automatic void model_step(input bit kin);
        bit sync_new;
        bit ks_old;
        bit all_diff;
        sync_new = (kq[0] == 1'b0);
        kq.delete(0);
        kq.push_back(kin);
        ks_old   = m_ks;
        all_diff = 1'b1;
        foreach (sq[i]) if (sq[i] == m_ks) all_diff = 1'b0;
        sq.delete(0);
        sq.push_back(sync_new);
        m_press = 0;
        m_long  = 0;
        if (!m_active) begin
            if (ks_old) begin
                m_active = 1; m_long_done = 0; m_enter = cyc;
            end
        end else if (!ks_old) begin
            if (!m_long_done) begin
                m_press = 1; m_valid = ~m_valid;
            end
            m_active = 0;
        end else if (!m_long_done && (cyc - m_enter == L + 1)) begin
            m_long = 1; m_valid = 0; m_long_done = 1;
        end
        if (all_diff) m_ks = ~m_ks;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_bit({tag, "_key_state"}, key_state, m_ks);
        check_bit({tag, "_valid"}, valid, m_valid);
        check_bit({tag, "_press"}, press_pulse, m_press);
        check_bit({tag, "_long"}, long_pulse, m_long);
    endtask

    task automatic tick(input string tag);
        @(posedge sys_clk);
        cyc++;
        if (rst) model_reset();
        else     model_step(key_in);
        #1;
        check_all(tag);
        if (key_state === 1'b1 && prev_ks === 1'b0) begin
            ks_rise_cyc = cyc; n_ks_rise++;
        end
        if (key_state === 1'b0 && prev_ks === 1'b1) ks_fall_cyc = cyc;
        if (press_pulse === 1'b1) begin press_cyc = cyc; n_press++; end
        if (long_pulse === 1'b1) begin long_cyc = cyc; n_long++; end
        prev_ks = key_state;
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic set_key(input logic v);
        if (v == 1'b0 && key_in == 1'b1) fall_cyc = cyc;
        if (v == 1'b1 && key_in == 1'b0) rel_cyc = cyc;
        key_in = v;
    endtask

    task automatic short_press(input string tag);
        set_key(1'b0);
        ticks(tag, 10);
        set_key(1'b1);
        ticks(tag, 10);
    endtask

    initial begin
        int p0, l0;
        int seg;
        logic lvl;

        // Reset with the key released.
        rst = 1'b0;
        key_in = 1'b1;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_all("reset_async");
        ticks("reset_hold", 3);
        rst = 1'b0;
        ticks("post_reset", 50);
        check_int("reset_no_press", n_press, 0);
        check_int("reset_no_long", n_long, 0);

        // Bounce rejection.
        for (int r = 0; r < 5; r++) begin
            set_key(1'b0);
            ticks("bounce", 3);
            set_key(1'b1);
            ticks("bounce", 3);
        end
        ticks("bounce_tail", 10);
        check_int("bounce_no_rise", n_ks_rise, 0);
        check_int("bounce_no_press", n_press, 0);

        // Short press toggles valid up, a second one toggles it back.
        short_press("short1");
        check_int("short1_rise_lat", ks_rise_cyc - (fall_cyc + 1), D + 3);
        check_int("short1_press_lat", press_cyc - ks_fall_cyc, 1);
        check_int("short1_key_lat", press_cyc - (rel_cyc + 1), D + 4);
        check_bit("short1_valid", valid, 1'b1);
        short_press("short2");
        check_bit("short2_valid", valid, 1'b0);
        check_int("short2_press_count", n_press, 2);

        // Long press from valid = 1.
        short_press("pre_long");
        check_bit("pre_long_valid", valid, 1'b1);
        p0 = n_press;
        l0 = n_long;
        set_key(1'b0);
        ticks("long_hold", 40);
        check_int("long_count", n_long - l0, 1);
        check_int("long_lat", long_cyc - ks_rise_cyc, L + 2);
        check_bit("long_valid", valid, 1'b0);
        set_key(1'b1);
        ticks("long_release", 12);
        check_int("long_no_press", n_press - p0, 0);
        short_press("after_long");
        check_bit("after_long_idle", valid, 1'b1);

        // Release lands exactly when the hold counter reaches LONG_CNT.
        p0 = n_press;
        l0 = n_long;
        set_key(1'b0);
        ticks("boundary", 21);
        set_key(1'b1);
        ticks("boundary", 12);
        check_int("boundary_press", n_press - p0, 1);
        check_int("boundary_no_long", n_long - l0, 0);
        check_bit("boundary_valid", valid, 1'b0);

        // One cycle longer becomes a long press with valid already 0.
        p0 = n_press;
        l0 = n_long;
        set_key(1'b0);
        ticks("boundary_long", 22);
        set_key(1'b1);
        ticks("boundary_long", 12);
        check_int("boundary_long_count", n_long - l0, 1);
        check_int("boundary_long_no_press", n_press - p0, 0);
        check_bit("boundary_long_valid", valid, 1'b0);

        // Reset while held in PRESSED with valid = 1.
        short_press("pre_rst");
        check_bit("pre_rst_valid", valid, 1'b1);
        set_key(1'b0);
        ticks("rst_press", 12);
        rst = 1'b1;
        #1;
        model_reset();
        check_bit("rst_mid_valid", valid, 1'b0);
        check_bit("rst_mid_key_state", key_state, 1'b0);
        prev_ks = key_state;
        ticks("rst_mid_hold", 2);
        rst = 1'b0;
        rst_cyc = cyc;
        ticks("rst_mid_held", 10);
        check_int("rst_mid_rise_lat", ks_rise_cyc - (rst_cyc + 1), D + 3);
        set_key(1'b1);
        ticks("rst_mid_release", 10);
        check_bit("rst_mid_valid_after", valid, 1'b1);

        // Random key activity against the model.
        lvl = 1'b1;
        for (int s = 0; s < 60; s++) begin
            lvl = ~lvl;
            set_key(lvl);
            seg = $urandom_range(1, 30);
            ticks("random", seg);
        end
        set_key(1'b1);
        ticks("random_tail", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
